// File: rtl/spi_reg_programmer.sv
// SPI register-sequence programmer: shifts NUM_REGS {data, addr} frames LSB-first under LE framing,
// then optionally reads every register back and flags the first data mismatch.
module spi_reg_programmer #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned DATA_W     = 28,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 64,
  parameter int unsigned READ_CMD   = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       verify,
  input  logic [NUM_REGS*ADDR_W-1:0] reg_addr,
  input  logic [NUM_REGS*DATA_W-1:0] reg_data,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [3:0]                 err_idx,
  output logic                       spi_clk,
  output logic                       spi_le,
  output logic                       spi_mosi,
  input  logic                       spi_miso
);

  localparam int unsigned F    = ADDR_W + DATA_W;
  localparam int unsigned BitW = $clog2(F + 1);
  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS + 1) : 1;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = $clog2(GAP_CYCLES);

  typedef enum logic [3:0] {
    StIdle, StLoad, StShift, StGap, StRLoad, StRCmd, StRGap, StRShift, StDone
  } state_e;

  state_e state_q, state_d;

  logic                       verify_q;
  logic [NUM_REGS*ADDR_W-1:0] addr_q;
  logic [NUM_REGS*DATA_W-1:0] data_q;
  logic [IdxW-1:0]            idx_q;
  logic [DivW-1:0]            div_q;
  logic [GapW-1:0]            gap_q;
  logic [BitW-1:0]            bit_q;
  logic                       sclk_q;
  logic                       lead_q;
  logic                       tail_q;
  logic                       rd_back_q;
  logic [F-1:0]               tx_q;
  logic [F-1:0]               rx_q;
  logic                       error_q;
  logic [3:0]                 err_idx_q;

  logic              tick;
  logic              gap_end;
  logic              last;
  logic              frame_end;
  logic              shift_st;
  logic              entering;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic [F-1:0]      load_word;

  assign tick      = (div_q == DivW'(CLK_DIV - 1));
  assign gap_end   = (gap_q == GapW'(GAP_CYCLES - 1));
  assign last      = (idx_q == IdxW'(NUM_REGS - 1));
  assign frame_end = tick && tail_q;
  assign shift_st  = (state_q == StShift) || (state_q == StRCmd) || (state_q == StRShift);
  assign entering  = (state_d != state_q);
  assign cur_addr  = addr_q[idx_q*ADDR_W +: ADDR_W];
  assign cur_data  = data_q[idx_q*DATA_W +: DATA_W];
  // Read-command frames carry the target register address in the data field.
  assign load_word = (state_q == StRLoad) ? {DATA_W'(cur_addr), ADDR_W'(READ_CMD)}
                                          : {cur_data, cur_addr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StLoad;
      StLoad:   if (tick) state_d = StShift;
      StShift:  if (frame_end) state_d = StGap;
      StGap: begin
        if (gap_end) begin
          if (!last)         state_d = StLoad;
          else if (verify_q) state_d = StRLoad;
          else               state_d = StDone;
        end
      end
      StRLoad:  if (tick) state_d = StRCmd;
      StRCmd:   if (frame_end) state_d = StRGap;
      StRGap: begin
        if (gap_end) begin
          if (!rd_back_q) state_d = StRShift;
          else if (!last) state_d = StRLoad;
          else            state_d = StDone;
        end
      end
      StRShift: if (frame_end) state_d = StRGap;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = 1'b1;
    done     = 1'b0;
    spi_le   = 1'b0;
    spi_mosi = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy   = 1'b0;
        spi_le = 1'b1;
      end
      StLoad, StRLoad:  spi_mosi = load_word[0];
      StShift, StRCmd:  spi_mosi = tx_q[0];
      StRShift:         spi_mosi = 1'b0;
      StGap, StRGap:    spi_le = 1'b1;
      StDone: begin
        busy   = 1'b0;
        done   = 1'b1;
        spi_le = 1'b1;
      end
      default: begin
        busy   = 1'b0;
        spi_le = 1'b1;
      end
    endcase
  end

  assign spi_clk = sclk_q;
  assign error   = error_q;
  assign err_idx = err_idx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      verify_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      div_q     <= '0;
      gap_q     <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      lead_q    <= 1'b0;
      tail_q    <= 1'b0;
      rd_back_q <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      div_q <= (entering || tick) ? '0 : div_q + 1'b1;
      gap_q <= entering ? '0 : gap_q + 1'b1;

      if (state_q == StIdle && start) begin
        verify_q  <= verify;
        addr_q    <= reg_addr;
        data_q    <= reg_data;
        idx_q     <= '0;
        error_q   <= 1'b0;
        err_idx_q <= '0;
      end
      if (state_q == StGap && gap_end) begin
        idx_q <= last ? '0 : idx_q + 1'b1;
      end
      if (state_q == StRGap && gap_end && rd_back_q && !last) begin
        idx_q <= idx_q + 1'b1;
      end

      // Readback frames get one extra low half-period up front so every frame has the same length.
      if (entering && (state_d == StShift || state_d == StRCmd || state_d == StRShift)) begin
        sclk_q <= 1'b0;
        bit_q  <= '0;
        tail_q <= 1'b0;
        lead_q <= (state_d == StRShift);
        tx_q   <= (state_d == StRShift) ? '0 : load_word;
      end else if (shift_st && tick && !tail_q) begin
        if (lead_q) begin
          lead_q <= 1'b0;
        end else if (!sclk_q) begin
          sclk_q <= 1'b1;
          bit_q  <= bit_q + 1'b1;
          if (state_q == StRShift) rx_q <= {spi_miso, rx_q[F-1:1]};
        end else begin
          sclk_q <= 1'b0;
          tx_q   <= tx_q >> 1;
          if (bit_q == BitW'(F)) tail_q <= 1'b1;
        end
      end

      if (state_q == StRCmd && frame_end) rd_back_q <= 1'b0;
      if (state_q == StRShift && frame_end) begin
        rd_back_q <= 1'b1;
        if (!error_q && rx_q[F-1:ADDR_W] != cur_data) begin
          error_q   <= 1'b1;
          err_idx_q <= 4'(idx_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_programmer.sv
// Bench for spi_reg_programmer: a cycle-position model derived from the frame-period formula,
// an SPI slave that decodes frames and echoes (optionally corrupted) register contents.
module tb_spi_reg_programmer;
  localparam int N   = 3;
  localparam int DW  = 28;
  localparam int AW  = 4;
  localparam int CD  = 2;
  localparam int GAP = 8;
  localparam int F   = AW + DW;
  localparam int PER = (2 * F + 2) * CD + GAP;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            verify = 1'b0;
  logic            miso = 1'b0;
  logic [N*AW-1:0] reg_addr = '0;
  logic [N*DW-1:0] reg_data = '0;
  logic            busy, done, error, sclk, le, mosi;
  logic [3:0]      err_idx;

  logic            start2 = 1'b0;
  logic [3:0]      a2 = 4'h9;
  logic [27:0]     d2 = 28'hABCDEF1;
  logic            busy2, done2, err2, sclk2, le2, mosi2;
  logic [3:0]      ei2;

  always #5 clk = ~clk;

  spi_reg_programmer #(
    .NUM_REGS(N), .DATA_W(DW), .ADDR_W(AW), .CLK_DIV(CD), .GAP_CYCLES(GAP), .READ_CMD(14)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .verify(verify), .reg_addr(reg_addr),
    .reg_data(reg_data), .busy(busy), .done(done), .error(error), .err_idx(err_idx),
    .spi_clk(sclk), .spi_le(le), .spi_mosi(mosi), .spi_miso(miso)
  );

  spi_reg_programmer #(
    .NUM_REGS(1), .DATA_W(28), .ADDR_W(4), .CLK_DIV(1), .GAP_CYCLES(2), .READ_CMD(14)
  ) dut2 (
    .clk(clk), .reset(reset), .start(start2), .verify(1'b0), .reg_addr(a2), .reg_data(d2),
    .busy(busy2), .done(done2), .error(err2), .err_idx(ei2), .spi_clk(sclk2), .spi_le(le2),
    .spi_mosi(mosi2), .spi_miso(1'b0)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: what was accepted, and how many edges have passed since.
  bit          m_active = 1'b0;
  int          m_k = 0;
  int          m_total = 0;
  bit          m_verify = 1'b0;
  logic [3:0]  m_addr [N];
  logic [27:0] m_data [N];

  // Slave device state.
  logic [27:0] dev_mem [16];
  logic [27:0] corrupt [16];
  logic [31:0] frames [$];
  int          nbits = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_active = 1'b0;
      end else if (m_active) begin
        if (m_k == m_total) m_active = 1'b0;
        else m_k++;
      end else if (start) begin
        m_active = 1'b1;
        m_k      = 0;
        m_verify = verify;
        m_total  = N * PER * (verify ? 3 : 1);
        for (int i = 0; i < N; i++) begin
          m_addr[i] = reg_addr[i*AW +: AW];
          m_data[i] = reg_data[i*DW +: DW];
        end
      end
    end
  end

  // SPI slave: decodes frames on spi_clk rising edges, answers read commands on the next frame.
  initial begin
    logic [31:0] cur, rd_word;
    logic [3:0]  a;
    bit          prev_clk, prev_le, rd_pending, rd_active;
    int          rd_bit;
    cur = '0; rd_word = '0; prev_clk = 1'b0; prev_le = 1'b1;
    rd_pending = 1'b0; rd_active = 1'b0; rd_bit = 0;
    for (int i = 0; i < 16; i++) begin
      dev_mem[i] = '0;
      corrupt[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (reset) begin
        nbits = 0; cur = '0; rd_pending = 1'b0; rd_active = 1'b0; miso = 1'b0;
      end else begin
        if (!le && prev_le) begin
          nbits = 0;
          cur   = '0;
          if (rd_pending) begin
            rd_active = 1'b1;
            rd_bit    = 0;
            miso      = rd_word[0];
          end
        end
        if (!le && sclk && !prev_clk) begin
          if (nbits < F) cur[nbits] = mosi;
          nbits++;
        end
        if (rd_active && !sclk && prev_clk) begin
          rd_bit++;
          miso = (rd_bit < F) ? rd_word[rd_bit] : 1'b0;
        end
        if (le && !prev_le) begin
          if (nbits == F) begin
            frames.push_back(cur);
            if (rd_active) begin
              rd_pending = 1'b0;
            end else if (cur[3:0] == 4'd14) begin
              a          = cur[7:4];
              rd_word    = {dev_mem[a] ^ corrupt[a], a};
              rd_pending = 1'b1;
            end else begin
              dev_mem[cur[3:0]] = cur[31:4];
            end
          end
          rd_active = 1'b0;
          miso      = 1'b0;
          nbits     = 0;
        end
      end
      prev_clk = sclk;
      prev_le  = le;
    end
  end

  // Per-cycle compare against the frame-period timeline, plus end-of-sequence checks.
  initial begin
    int          p, h, eidx;
    bit          ebusy, edone, eframe, eclk, eerr;
    logic [31:0] exp_q [$];
    forever begin
      @(negedge clk);
      if (!reset) begin
        ebusy  = m_active && (m_k < m_total);
        edone  = m_active && (m_k == m_total);
        p      = m_k % PER;
        h      = p / CD;
        eframe = ebusy && (p < (2 * F + 2) * CD);
        eclk   = eframe && (h >= 2) && (h <= 2 * F) && (h % 2 == 0);
        check("busy", busy, ebusy);
        check("done", done, edone);
        check("spi_le", le, !eframe);
        check("spi_clk", sclk, eclk);
        if (le) check("mosi_idle", mosi, 1'b0);
        if (edone) begin
          exp_q.delete();
          for (int i = 0; i < N; i++) exp_q.push_back((32'(m_data[i]) << AW) | 32'(m_addr[i]));
          eerr = 1'b0;
          eidx = 0;
          if (m_verify) begin
            for (int i = 0; i < N; i++) begin
              exp_q.push_back((32'(m_addr[i]) << AW) | 32'd14);
              exp_q.push_back(32'd0);
              if (!eerr && corrupt[m_addr[i]] != 0) begin
                eerr = 1'b1;
                eidx = i;
              end
            end
          end
          check("frame_count", frames.size(), exp_q.size());
          for (int i = 0; i < exp_q.size() && i < frames.size(); i++)
            check($sformatf("frame[%0d]", i), frames[i], exp_q[i]);
          check("error_at_done", error, eerr);
          if (eerr) check("err_idx", err_idx, eidx);
        end
      end
    end
  end

  task automatic kick(input logic v);
    frames.delete();
    @(negedge clk);
    verify = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    check("error_cleared_by_start", error, 1'b0);
  endtask

  task automatic wait_done(input bit disturb, output int lat);
    int extra;
    lat = 0;
    while (!done && lat < 6000) begin
      @(negedge clk);
      lat++;
      start = disturb && (lat == 100 || lat == 301);
      if (disturb && lat == 150) begin
        reg_data = {N{28'hFFFFFFF}};
        verify   = 1'b1;
      end
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    if (disturb) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      extra = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("extra_done_pulses", extra, 0);
    end
  endtask

  task automatic run_seq(input logic v, input bit disturb, output int lat);
    kick(v);
    wait_done(disturb, lat);
  endtask

  task automatic run_small();
    int          lat, nr, last_rise, bad;
    bit          prev;
    logic [31:0] word;
    lat = 0; nr = 0; last_rise = -1; bad = 0; prev = 1'b0; word = '0;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    while (!done2 && lat < 500) begin
      @(negedge clk);
      lat++;
      if (sclk2 && !prev) begin
        if (nr < 32 && !le2) word[nr] = mosi2;
        if (last_rise >= 0 && lat - last_rise != 2) bad++;
        last_rise = lat;
        nr++;
      end
      prev = sclk2;
    end
    check("small_done_latency", lat, 68);
    check("small_rises", nr, 32);
    check("small_clk_period", bad, 0);
    check("small_word", word, {d2, a2});
    check("small_busy_at_done", busy2, 1'b0);
    check("small_error", {err2, ei2}, 5'd0);
  endtask

  initial begin
    int  lat, guard;
    bit  found;
    int  base;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_err_idx", err_idx, 4'd0);
    check("rst_spi_clk", sclk, 1'b0);
    check("rst_spi_le", le, 1'b1);
    check("rst_spi_mosi", mosi, 1'b0);
    reset = 1'b0;

    reg_addr = {4'd2, 4'd1, 4'd0};
    reg_data = {28'h0000180, 28'h8A3C1F5, 28'h1234567};
    run_seq(1'b0, 1'b0, lat);
    check("write_latency", lat, 420);
    check("write_frame0_literal", frames.size() > 0 ? frames[0] : 32'hX, 32'h12345670);
    check("write_frame2_literal", frames.size() > 2 ? frames[2] : 32'hX, 32'h00001802);

    run_seq(1'b1, 1'b0, lat);
    check("verify_latency", lat, 1260);
    check("rcmd_frame_literal", frames.size() > 5 ? frames[5] : 32'hX, 32'h0000001E);
    check("verify_pass_error", error, 1'b0);

    corrupt[1] = 28'h0000020;
    corrupt[2] = 28'h0F0F0F0;
    run_seq(1'b1, 1'b0, lat);
    check("verify_fail_error", error, 1'b1);
    check("verify_fail_idx", err_idx, 4'd1);
    check("verify_fail_frames", frames.size(), 9);
    corrupt[1] = '0;
    corrupt[2] = '0;
    run_seq(1'b0, 1'b0, lat);

    run_seq(1'b0, 1'b1, lat);
    reg_data = {28'h0000180, 28'h8A3C1F5, 28'h1234567};

    kick(1'b0);
    found = 1'b0;
    guard = 0;
    while (!found && guard < 2000) begin
      @(negedge clk);
      guard++;
      found = (frames.size() == 1) && (nbits == 17);
    end
    check("bit17_reached", found, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_le", le, 1'b1);
    check("midrst_clk", sclk, 1'b0);
    check("midrst_mosi", mosi, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_seq(1'b1, 1'b0, lat);
    check("post_reset_latency", lat, 1260);

    for (int it = 0; it < 4; it++) begin
      base = $urandom_range(0, 13);
      for (int i = 0; i < N; i++) begin
        reg_addr[i*AW +: AW] = 4'((base + i) % 14);
        reg_data[i*DW +: DW] = 28'($urandom);
      end
      for (int i = 0; i < 16; i++)
        corrupt[i] = ($urandom_range(0, 2) == 0) ? (28'($urandom) | (28'd1 << $urandom_range(0, 27)))
                                                 : 28'd0;
      run_seq(1'($urandom_range(0, 1)), 1'b0, lat);
    end
    for (int i = 0; i < 16; i++) corrupt[i] = '0;

    run_small();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
